// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer raising IRQ as a one-shot or periodic source.
// Build with TIMER_PERIODIC_EN defined to enable MODE 01 periodic auto-reload.
module timer_dev #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  // state | meaning
  // IDLE  | stopped, waiting for EN
  // LOAD  | copy PRESET into COUNT
  // CNT   | decrementing COUNT toward 0
  // INT   | terminal count reached, interrupt cycle
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;
  logic        sel, wr_ctrl, wr_preset;
  logic        en, im, periodic, oneshot_int;

  assign sel       = (Addr[31:4] == BASE[31:4]);
  assign wr_ctrl   = sel & WE & (Addr[3:2] == 2'd0);
  assign wr_preset = sel & WE & (Addr[3:2] == 2'd1);
  assign en        = ctrl[0];
  assign im        = ctrl[3];

`ifdef TIMER_PERIODIC_EN
  assign periodic = (ctrl[2:1] == 2'b01);
`else
  assign periodic = 1'b0;
`endif

  assign oneshot_int = (state == INT) & ~periodic;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = LOAD;
      LOAD:    state_nxt = CNT;
      CNT: begin
        if (!en)
          state_nxt = IDLE;
        else if (count == 32'd0)
          state_nxt = INT;
      end
      default: state_nxt = periodic ? LOAD : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ctrl    <= 4'd0;
      preset  <= 32'd0;
      count   <= 32'd0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == LOAD)
        count <= preset;
      else if ((state == CNT) && en && (count != 32'd0))
        count <= count - 32'd1;

      if (wr_preset)
        preset <= Din;

      // a CPU write to CTRL beats the FSM clearing EN at the same edge
      if (wr_ctrl)
        ctrl <= Din[3:0];
      else if (oneshot_int)
        ctrl[0] <= 1'b0;

      if (oneshot_int)
        pending <= 1'b1;
      else if (wr_ctrl || wr_preset)
        pending <= 1'b0;
    end
  end

  // pending is only ever set in one-shot INT, so the INT term gives the periodic pulse
  // and also lets the one-shot IRQ rise in the INT cycle itself
  assign IRQ = im & (pending | (state == INT));

  always_comb begin
    Dout = 32'd0;
    if (sel) begin
      case (Addr[3:2])
        2'd0:    Dout = {28'd0, ctrl};
        2'd1:    Dout = preset;
        2'd2:    Dout = count;
        default: Dout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev; expectations follow TIMER_PERIODIC_EN when defined.
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] r;

  timer_dev #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    @(negedge clk);
    Addr = {BASE[31:4], idx};
    WE   = 1'b1;
    Din  = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] d);
    Addr = {BASE[31:4], idx};
    #1;
    d = Dout;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    step(3);
    reset = 1'b0;

    // reset values
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    rd(2'd0, r); chk("rst_ctrl", r, 32'd0);
    rd(2'd1, r); chk("rst_preset", r, 32'd0);
    rd(2'd2, r); chk("rst_count", r, 32'd0);

    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    chk("os_irq_t0", {31'd0, IRQ}, 32'd0);
    step(2);
    rd(2'd2, r); chk("os_count_t2", r, 32'd5);
    step(5);
    rd(2'd2, r); chk("os_count_t7", r, 32'd0);
    chk("os_irq_t7", {31'd0, IRQ}, 32'd0);
    step(1);
    chk("os_irq_t8", {31'd0, IRQ}, 32'd1);
    step(1);
    rd(2'd0, r); chk("os_ctrl_en_clr", r, 32'h8);
    chk("os_irq_t9", {31'd0, IRQ}, 32'd1);
    step(3);
    chk("os_irq_hold", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h0);
    chk("os_irq_drop", {31'd0, IRQ}, 32'd0);

    // PRESET=0 latency 3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    chk("p0_irq_t2", {31'd0, IRQ}, 32'd0);
    step(1);
    chk("p0_irq_t3", {31'd0, IRQ}, 32'd1);
    step(2);
    wr(2'd0, 32'h0);
    chk("p0_irq_clr", {31'd0, IRQ}, 32'd0);

    // periodic request, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step(5);
    chk("per_irq_t5", {31'd0, IRQ}, 32'd0);
    step(1);
    chk("per_irq_t6", {31'd0, IRQ}, 32'd1);
    step(1);
`ifdef TIMER_PERIODIC_EN
    chk("per_irq_t7", {31'd0, IRQ}, 32'd0);
`else
    chk("per_irq_t7", {31'd0, IRQ}, 32'd1);
`endif
    step(4);
`ifdef TIMER_PERIODIC_EN
    chk("per_irq_t11", {31'd0, IRQ}, 32'd0);
`else
    chk("per_irq_t11", {31'd0, IRQ}, 32'd1);
`endif
    step(1);
    chk("per_irq_t12", {31'd0, IRQ}, 32'd1);
    rd(2'd0, r);
`ifdef TIMER_PERIODIC_EN
    chk("per_ctrl", r, 32'hB);
`else
    chk("per_ctrl", r, 32'hA);
`endif
    wr(2'd0, 32'h0);
    step(4);
    chk("per_irq_off", {31'd0, IRQ}, 32'd0);

    // disable mid-count, then re-enable
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(7);
    rd(2'd2, r); chk("dis_count_t7", r, 32'd5);
    wr(2'd0, 32'h8);
    rd(2'd2, r); chk("dis_count_t8", r, 32'd4);
    step(5);
    rd(2'd2, r); chk("dis_count_hold", r, 32'd4);
    chk("dis_irq", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    rd(2'd2, r); chk("dis_reload", r, 32'd10);
    wr(2'd0, 32'h0);
    step(3);

    // PRESET write while counting does not disturb the run
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    step(2);
    rd(2'd2, r); chk("pw_count_t2", r, 32'd8);
    wr(2'd1, 32'd20);
    rd(2'd2, r); chk("pw_count_t3", r, 32'd7);
    step(7);
    chk("pw_irq_t10", {31'd0, IRQ}, 32'd0);
    step(1);
    chk("pw_irq_t11", {31'd0, IRQ}, 32'd1);
    step(1);
    wr(2'd1, 32'd20);
    chk("pw_pend_clr", {31'd0, IRQ}, 32'd0);
    rd(2'd0, r); chk("pw_ctrl", r, 32'h8);

    // periodic reload picks up the new PRESET
    wr(2'd1, 32'd8);
    wr(2'd0, 32'hB);
    step(2);
    wr(2'd1, 32'd20);
    step(8);
    chk("pr_irq_t11", {31'd0, IRQ}, 32'd1);
    step(2);
    rd(2'd2, r);
`ifdef TIMER_PERIODIC_EN
    chk("pr_reload", r, 32'd20);
`else
    chk("pr_reload", r, 32'd0);
`endif
    wr(2'd0, 32'h0);
    step(3);

    // maximum PRESET counts down without wrap
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    step(3);
    rd(2'd2, r); chk("max_count_t3", r, 32'hFFFF_FFFE);
    chk("max_irq", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h0);
    step(2);

    // reset in the middle of a count
    wr(2'd1, 32'd12);
    wr(2'd0, 32'h9);
    step(7);
    rd(2'd2, r); chk("mr_count_t7", r, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mr_irq", {31'd0, IRQ}, 32'd0);
    rd(2'd0, r); chk("mr_ctrl", r, 32'd0);
    rd(2'd1, r); chk("mr_preset", r, 32'd0);
    rd(2'd2, r); chk("mr_count", r, 32'd0);

    // COUNT is read-only, reserved reads 0, decode is exact
    wr(2'd2, 32'h55);
    rd(2'd2, r); chk("count_ro", r, 32'd0);
    wr(2'd3, 32'h77);
    rd(2'd3, r); chk("reserved", r, 32'd0);
    wr(2'd1, 32'hABCD);
    rd(2'd1, r); chk("preset_rw", r, 32'hABCD);
    Addr = {BASE[31:4] + 28'd1, 2'd1};
    #1;
    chk("unsel_read", Dout, 32'd0);
    @(negedge clk);
    WE  = 1'b1;
    Din = 32'h1234;
    @(posedge clk);
    #1;
    WE = 1'b0;
    rd(2'd1, r); chk("unsel_write", r, 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
